// File: rtl/fpu_pkg.sv
// fpu_pkg: shared definitions for the FPU operand front-end.
//   fp_class_e    : bit index of each class inside the one-hot class vector
//   CLS_W         : width of the one-hot class vector
//   op_width()    : packed operand width {sign,exp,man}
//   fp_unpacked_t : unpacked operand at the package default widths
package fpu_pkg;

  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_SUB  = 3'd1,
    CLS_NORM = 3'd2,
    CLS_INF  = 3'd3,
    CLS_QNAN = 3'd4,
    CLS_SNAN = 3'd5
  } fp_class_e;

  localparam int CLS_W     = 6;
  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;
  localparam int OP_W_DEF  = 1 + EXP_W_DEF + MAN_W_DEF;

  // Class vector value held while the output is idle after reset.
  localparam logic [CLS_W-1:0] CLS_RST = 6'b000001;

  function automatic int op_width(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  typedef struct packed {
    logic                 sign;
    logic [EXP_W_DEF-1:0] exp;
    logic [MAN_W_DEF:0]   sig;
    logic [CLS_W-1:0]     cls;
  } fp_unpacked_t;

endpackage

// File: rtl/fp_classify.sv
// fp_classify: combinational classify / fix-up of one IEEE-754 operand.
//   op      : packed operand {sign,exp,man}
//   daz     : treat subnormals as signed zero
//   sign    : operand sign
//   exp_eff : effective exponent (subnormal -> 1, zero -> 0)
//   sig     : {hidden,man}
//   cls     : one-hot {snan,qnan,inf,norm,sub,zero}
module fp_classify
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] op,
  input  logic                 daz,
  output logic                 sign,
  output logic [EXP_W-1:0]     exp_eff,
  output logic [MAN_W:0]       sig,
  output logic [CLS_W-1:0]     cls
);

  logic [EXP_W-1:0] e;
  logic [MAN_W-1:0] m;
  logic             exp_zero, exp_ones, man_zero;

  assign sign     = op[EXP_W+MAN_W];
  assign e        = op[MAN_W +: EXP_W];
  assign m        = op[MAN_W-1:0];
  assign exp_zero = (e == '0);
  assign exp_ones = &e;
  assign man_zero = (m == '0);

  always_comb begin
    cls     = '0;
    exp_eff = e;
    sig     = {1'b1, m};
    if (exp_zero) begin
      // DAZ flushes the subnormal mantissa but keeps the sign.
      if (man_zero || daz) begin
        cls[CLS_ZERO] = 1'b1;
        exp_eff       = '0;
        sig           = '0;
      end else begin
        cls[CLS_SUB]  = 1'b1;
        exp_eff       = EXP_W'(1);
        sig           = {1'b0, m};
      end
    end else if (!exp_ones) begin
      cls[CLS_NORM] = 1'b1;
    end else if (man_zero) begin
      cls[CLS_INF]  = 1'b1;
    end else if (m[MAN_W-1]) begin
      cls[CLS_QNAN] = 1'b1;
    end else begin
      cls[CLS_SNAN] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_operand_unpack.sv
// fp_operand_unpack: registered operand front-end with a one-entry skid.
//   clk, rst_n        : clock, async active-low reset
//   daz               : denormals-are-zero (only when FPU_DAZ_EN is defined)
//   in_valid/in_ready : input handshake; in_ready is registered (!skid full)
//   in_ops, in_tag    : NUM_OPS packed operands, opaque sideband
//   out_valid/ready   : output handshake
//   out_sign/exp/sig/class : per-operand unpacked fields
//   out_any_nan/snan  : NaN / signalling-NaN summary over operands
//   out_tag           : sideband
// Optional feature macro: FPU_DAZ_EN adds the daz input.
module fp_operand_unpack
  import fpu_pkg::*;
#(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int NUM_OPS = 2,
  parameter int TAG_W   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
`ifdef FPU_DAZ_EN
  input  logic                           daz,
`endif
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_OPS*(1+EXP_W+MAN_W)-1:0] in_ops,
  input  logic [TAG_W-1:0]               in_tag,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_OPS-1:0]             out_sign,
  output logic [NUM_OPS*EXP_W-1:0]       out_exp,
  output logic [NUM_OPS*(MAN_W+1)-1:0]   out_sig,
  output logic [NUM_OPS*CLS_W-1:0]       out_class,
  output logic                           out_any_nan,
  output logic                           out_any_snan,
  output logic [TAG_W-1:0]               out_tag
);

  localparam int OP_W = op_width(EXP_W, MAN_W);

  logic daz_i;
`ifdef FPU_DAZ_EN
  assign daz_i = daz;
`else
  assign daz_i = 1'b0;
`endif

  // c_* : classified input, m_* : main (output) register, s_* : skid register
  logic [NUM_OPS-1:0]            c_sign, m_sign, s_sign;
  logic [NUM_OPS-1:0][EXP_W-1:0] c_exp, m_exp, s_exp;
  logic [NUM_OPS-1:0][MAN_W:0]   c_sig, m_sig, s_sig;
  logic [NUM_OPS-1:0][CLS_W-1:0] c_cls, m_cls, s_cls;
  logic [TAG_W-1:0]              m_tag, s_tag;
  logic                          m_valid, s_valid;

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls (
      .op     (in_ops[i*OP_W +: OP_W]),
      .daz    (daz_i),
      .sign   (c_sign[i]),
      .exp_eff(c_exp[i]),
      .sig    (c_sig[i]),
      .cls    (c_cls[i])
    );
  end

  logic accept, drain, load_main;
  assign accept    = in_valid & ~s_valid;
  assign drain     = m_valid & out_ready;
  assign load_main = drain | ~m_valid;

  // in_ready is low whenever skid is full, so a skid->main move never
  // coincides with an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_sign  <= '0;
      m_exp   <= '0;
      m_sig   <= '0;
      m_cls   <= {NUM_OPS{CLS_RST}};
      m_tag   <= '0;
      s_sign  <= '0;
      s_exp   <= '0;
      s_sig   <= '0;
      s_cls   <= {NUM_OPS{CLS_RST}};
      s_tag   <= '0;
    end else if (load_main) begin
      if (s_valid) begin
        m_valid <= 1'b1;
        s_valid <= 1'b0;
        m_sign  <= s_sign;
        m_exp   <= s_exp;
        m_sig   <= s_sig;
        m_cls   <= s_cls;
        m_tag   <= s_tag;
      end else begin
        m_valid <= accept;
        if (accept) begin
          m_sign <= c_sign;
          m_exp  <= c_exp;
          m_sig  <= c_sig;
          m_cls  <= c_cls;
          m_tag  <= in_tag;
        end
      end
    end else if (accept) begin
      // main is stalled: park the new transaction
      s_valid <= 1'b1;
      s_sign  <= c_sign;
      s_exp   <= c_exp;
      s_sig   <= c_sig;
      s_cls   <= c_cls;
      s_tag   <= in_tag;
    end
  end

  assign in_ready  = ~s_valid;
  assign out_valid = m_valid;
  assign out_sign  = m_sign;
  assign out_exp   = m_exp;
  assign out_sig   = m_sig;
  assign out_class = m_cls;
  assign out_tag   = m_tag;

  always_comb begin
    out_any_nan  = 1'b0;
    out_any_snan = 1'b0;
    for (int i = 0; i < NUM_OPS; i++) begin
      out_any_nan  = out_any_nan | m_cls[i][CLS_QNAN] | m_cls[i][CLS_SNAN];
      out_any_snan = out_any_snan | m_cls[i][CLS_SNAN];
    end
  end

endmodule

// File: doc/fp_operand_unpack.md
Name: fp_operand_unpack

Overview:
Parametrised, pipelined operand front-end for the FPU datapath. Takes NUM_OPS packed IEEE-754 operands per transaction. For each operand it produces the sign, the effective exponent (subnormal exponent forced to 1), the significand with the hidden bit applied, and a one-hot class. It sits between the instruction/register-read stage and the add/mul/div cores. It replaces the combinational zero/subnormal fix-up with a valid/ready registered stage that can sustain one transaction per cycle under backpressure.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored mantissa field width (hidden bit excluded)
NUM_OPS, 2, operands per transaction (1..3)
TAG_W, 4, opaque sideband carried alongside the data (op id/rounding mode)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  input transaction valid
in_ready  out  1  stage can accept
in_ops  in  NUM_OPS*(1+EXP_W+MAN_W)  operand i at [i*OP_W +: OP_W], OP_W=1+EXP_W+MAN_W, layout {sign,exp,man}
in_tag  in  TAG_W  sideband
out_valid  out  1  output valid
out_ready  in  1  downstream accepts
out_sign  out  NUM_OPS  sign per operand
out_exp  out  NUM_OPS*EXP_W  effective exponent
out_sig  out  NUM_OPS*(MAN_W+1)  {hidden,man}
out_class  out  NUM_OPS*6  one-hot {snan,qnan,inf,norm,sub,zero}, bit0=zero
out_any_nan  out  1  OR of qnan|snan over operands
out_any_snan  out  1  OR of snan over operands (invalid-op flag source)
out_tag  out  TAG_W  sideband

Behaviour:
- Classification per operand (combinational, pre-register):
  - exp==0, man==0: zero; exp_eff=0, hidden=0.
  - exp==0, man!=0: sub; exp_eff=1, hidden=0.
  - 0<exp<all-ones: norm; exp_eff=exp, hidden=1.
  - exp all-ones, man==0: inf; hidden=1, exp_eff=exp.
  - exp all-ones, man!=0: NaN; qnan if man[MAN_W-1]=1, else snan; hidden=1, exp_eff=exp.
  - Exactly one class bit is set at all times when out_valid=1.
- Pipeline: one register stage plus a one-entry skid register. Latency is 1 cycle (in_valid&in_ready at edge N gives out_valid at N+1 if the stage was empty).
- in_ready = !skid_valid (registered; no combinational path from out_ready to in_ready).
- Transfer rules:
  - Accept when in_valid&in_ready. If the main register is full and not draining (out_valid&!out_ready), the accepted data goes to skid.
  - When main drains and skid is full, skid moves to main and skid clears.
- Output data is held stable while out_valid&!out_ready. No drop and no duplication; order is preserved.
- Simultaneous accept and drain with skid empty: the main register reloads with the new data, throughput 1/cycle.
- Reset (async assert, sync release by the top level):
  - out_valid=0, skid_valid=0, in_ready=1 after reset.
  - All data outputs reset to 0, with out_class=6'b000001 (zero) per operand.
  - Reset mid-transfer discards all held transactions.
- in_ops/in_tag are ignored when in_valid=0. out_* data is don't-care except as reset when out_valid=0.

Optional Feature:
FPU_DAZ_EN (denormals-are-zero).
- Defined: adds input port daz (1 bit), sampled with the transaction. When daz=1, subnormal inputs classify as zero with exp_eff=0 and sig=0; the sign is preserved.
- Undefined: the port is absent and subnormals are always handled as above.

Decomposition:
- Package fpu_pkg holds:
  - fp_class_e with enum index constants CLS_ZERO..CLS_SNAN and CLS_W=6.
  - localparam helpers for OP_W.
  - the struct fp_unpacked_t {sign, exp, sig, cls}, parametrised through the package defaults.
- One sub-module, fp_classify: combinational classify/fix-up for a single operand, instantiated NUM_OPS times in a generate loop. The parent owns the handshake, skid and registers.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> out_valid=0, in_ready=1, out_class=000001 immediately (async).
- Classes (defaults, op0/op1):
  - 0x00000000 -> zero, exp 0, sig 0x000000.
  - 0x00000001 -> sub, exp 1, sig 0x000001.
  - 0x3F800000 -> norm, exp 0x7F, sig 0x800000.
  - 0xFF800000 -> inf, sign 1.
  - 0x7FC00000 -> qnan.
  - 0x7F800001 -> snan, any_snan=1.
- Throughput: in_valid=1 with 8 back-to-back transactions and out_ready=1 -> 8 outputs on consecutive cycles, 1-cycle latency, tags 0..7 in order.
- Backpressure: out_ready=0 for 3 cycles while in_valid=1 -> in_ready drops after the second accept, output held stable, no loss; resume gives the correct sequence.
- Parametrisation: EXP_W=11, MAN_W=52, NUM_OPS=3:
  - 0x0000000000000001 -> sub, exp 1.
  - 0x7FF8000000000000 -> qnan.
- DAZ (FPU_DAZ_EN): daz=1 with 0x80000001 -> zero, sign 1, sig 0. daz=0 with the same input -> sub.
